// File: rtl/uart_bus_slave_pkg.sv
// rtl/uart_bus_slave_pkg.sv - register map, status bit layout and shared FSM state type
package uart_bus_slave_pkg;

  localparam logic [31:0] UART_DATA_OFFSET   = 32'h0;
  localparam logic [31:0] UART_STATUS_OFFSET = 32'h4;

  localparam int TX_READY  = 0;
  localparam int RX_VALID  = 1;
  localparam int FRAME_ERR = 2;
  localparam int OVERRUN   = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  function automatic logic [31:0] status_word(input logic overrun, input logic frame_err,
                                              input logic rx_valid, input logic tx_ready);
    logic [31:0] w;
    w            = '0;
    w[TX_READY]  = tx_ready;
    w[RX_VALID]  = rx_valid;
    w[FRAME_ERR] = frame_err;
    w[OVERRUN]   = overrun;
    return w;
  endfunction

endpackage

// File: rtl/uart_bus_slave_if.sv
// rtl/uart_bus_slave_if.sv - CPU bus and UART pin interfaces
interface bus_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] data_wr;
  logic [3:0]  mask;
  logic        stall;
  logic [31:0] data_rd;
  logic [31:0] data_rd_2;

  modport master (output address, read, write, data_wr, mask,
                  input  stall, data_rd, data_rd_2);
  modport slave  (input  address, read, write, data_wr, mask,
                  output stall, data_rd, data_rd_2);
endinterface

interface uart_if;
  logic txd;
  logic rxd;

  modport master (output txd, input rxd);
  modport peer   (input txd, output rxd);
endinterface

// File: rtl/uart_bus_slave_fifo.sv
// rtl/uart_bus_slave_fifo.sv - synchronous first-word-fall-through FIFO
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_bus_slave.sv
// rtl/uart_bus_slave.sv - bus-mapped 8N1 UART with TX/RX FIFOs and sticky error status
module uart_bus_slave
  import uart_bus_slave_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DIV      = CLK_FREQ / BAUD,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input logic    clk,
  input logic    rst,
  bus_if.slave   bus,
  uart_if.master uart
);
  localparam int            TW       = $clog2(DIV);
  localparam logic [TW-1:0] BIT_END  = TW'(DIV - 1);
  localparam logic [TW-1:0] HALF_END = TW'(DIV / 2 - 1);

  logic       is_status, rd_req, status_rd, tx_push_req, tx_push, rx_pop;
  logic       tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push;
  logic [7:0] tx_dout, rx_dout;
  logic       overrun, frame_err, overrun_evt, frame_err_evt;
  logic [31:0] rd_word;
  logic       unused_bits;

  assign unused_bits = ^{bus.address[31:3], bus.address[1:0], bus.data_wr[31:8], bus.mask[3:1]};

  assign is_status   = (bus.address[2] == UART_STATUS_OFFSET[2]) && (bus.address[2] != UART_DATA_OFFSET[2]);
  assign rd_req      = bus.read && !bus.write;
  assign status_rd   = rd_req && is_status;
  assign rx_pop      = rd_req && !is_status;
  assign tx_push_req = bus.write && !is_status && bus.mask[0];
  assign tx_push     = tx_push_req && !tx_full;

  always_comb begin
    rd_word = '0;
    if (rd_req) begin
      if (is_status) rd_word = status_word(overrun, frame_err, !rx_empty, !tx_full);
      else if (!rx_empty) rd_word = {24'h0, rx_dout};
    end
  end

  assign bus.stall     = tx_push_req && tx_full;
  assign bus.data_rd   = rd_word;
  assign bus.data_rd_2 = '0;

  uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(bus.data_wr[7:0]),
    .dout(tx_dout), .full(tx_full), .empty(tx_empty)
  );

  // ---------------- transmitter ----------------
  uart_state_t   tx_state, tx_state_n;
  logic [TW-1:0] tx_timer, tx_timer_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_shift, tx_shift_n;
  logic          txd_q, txd_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_timer <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_timer <= tx_timer_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txd_q    <= txd_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_timer_n = tx_timer + 1'b1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_timer_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_dout;
          tx_bit_n   = '0;
          tx_state_n = START;
        end
      end
      START: if (tx_timer == BIT_END) begin
        tx_timer_n = '0;
        tx_state_n = DATA;
      end
      DATA: if (tx_timer == BIT_END) begin
        tx_timer_n = '0;
        tx_shift_n = tx_shift >> 1;
        tx_bit_n   = tx_bit + 1'b1;
        if (tx_bit == 3'd7) tx_state_n = STOP;
      end
      STOP: if (tx_timer == BIT_END) begin
        tx_timer_n = '0;
        tx_bit_n   = '0;
        // Chain straight into the next start bit so queued bytes leave no idle gap.
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_dout;
          tx_state_n = START;
        end else begin
          tx_state_n = IDLE;
        end
      end
      default: tx_state_n = IDLE;
    endcase
    case (tx_state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = tx_shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

  assign uart.txd = txd_q;

  // ---------------- receiver ----------------
  logic [1:0]    rx_sync;
  logic          rx_s;
  uart_state_t   rx_state, rx_state_n;
  logic [TW-1:0] rx_timer, rx_timer_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_brk, rx_brk_n;

  assign rx_s = rx_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync  <= 2'b11;
      rx_state <= IDLE;
      rx_timer <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_brk   <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], uart.rxd};
      rx_state <= rx_state_n;
      rx_timer <= rx_timer_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx_brk   <= rx_brk_n;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_timer_n    = rx_timer + 1'b1;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_brk_n      = rx_brk;
    rx_push       = 1'b0;
    frame_err_evt = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_timer_n = '0;
        if (!rx_s) rx_state_n = START;
      end
      START: if (rx_timer == HALF_END) begin
        rx_timer_n = '0;
        rx_bit_n   = '0;
        rx_state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (rx_timer == BIT_END) begin
        rx_timer_n = '0;
        rx_shift_n = {rx_s, rx_shift[7:1]};
        rx_bit_n   = rx_bit + 1'b1;
        if (rx_bit == 3'd7) rx_state_n = STOP;
      end
      STOP: begin
        // After a bad stop bit the line must return high before hunting for a new start.
        if (rx_brk) begin
          rx_timer_n = '0;
          if (rx_s) begin
            rx_brk_n   = 1'b0;
            rx_state_n = IDLE;
          end
        end else if (rx_timer == BIT_END) begin
          rx_timer_n = '0;
          if (rx_s) begin
            rx_push    = 1'b1;
            rx_state_n = IDLE;
          end else begin
            frame_err_evt = 1'b1;
            rx_brk_n      = 1'b1;
          end
        end
      end
      default: rx_state_n = IDLE;
    endcase
  end

  assign overrun_evt = rx_push && rx_full && !rx_pop;

  uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_shift),
    .dout(rx_dout), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= overrun_evt   | (overrun   & ~status_rd);
      frame_err <= frame_err_evt | (frame_err & ~status_rd);
    end
  end

endmodule
